pmod_axil_slave_regs: RTL and testbench

- AXI4-Lite responder (slave) register block for the PMod544IOR2 peripheral.
- Sits behind the interconnect and answers the single-beat write and read transactions issued by the AXI4-Lite master.
- Exposes four 32-bit word registers.
- Drives PMod output and output-enable pins from two of them, and returns synchronized PMod input pins through a read-only register.

---
 rtl/pmod_axil_slave_regs_if.sv | 40 ++++
 rtl/pmod_axil_slave_regs.sv | 178 +++++++++++++++++
 tb/tb_pmod_axil_slave_regs.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmod_axil_slave_regs_if.sv
// AXI4-Lite bus bundle between the interconnect master and the PMod register slave.
interface pmod_axil_slave_regs_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]            S_AXI_AWPROT;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [31:0]           S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]            S_AXI_ARPROT;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [31:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/pmod_axil_slave_regs.sv
// AXI4-Lite register slave for PMod544IOR2: REG0 drives pins, REG1 output enables,
// REG2 returns synchronized pin inputs, REG3 is scratch.
module pmod_axil_slave_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PMOD_WIDTH = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  pmod_axil_slave_regs_if.slave s_axi,
  output logic [PMOD_WIDTH-1:0] pmod_out,
  output logic [PMOD_WIDTH-1:0] pmod_oe,
  input  logic [PMOD_WIDTH-1:0] pmod_in
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [DATA_WIDTH-1:0]   reg0, reg1, reg3;
  logic [PMOD_WIDTH-1:0]   sync1, sync2;
  logic [DATA_WIDTH-1:0]   pmod_ext;

  logic                    aw_got, w_got;
  logic [2:0]              awidx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;

  logic                    aw_hs, w_hs, commit, ar_hs;
  logic [2:0]              wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0]   old_val,
    input logic [DATA_WIDTH-1:0]   new_val,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int unsigned i = 0; i < DATA_WIDTH/8; i++)
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  assign pmod_out = reg0[PMOD_WIDTH-1:0];
  assign pmod_oe  = reg1[PMOD_WIDTH-1:0];

  // AW and W are latched separately; the commit uses whichever copy (latched or live) is current.
  always_comb begin
    w_state_nxt         = w_state;
    s_axi.S_AXI_AWREADY = 1'b0;
    s_axi.S_AXI_WREADY  = 1'b0;
    s_axi.S_AXI_BVALID  = 1'b0;
    aw_hs               = 1'b0;
    w_hs                = 1'b0;
    commit              = 1'b0;
    wr_idx              = aw_got ? awidx_q : s_axi.S_AXI_AWADDR[4:2];
    wr_data             = w_got ? wdata_q : s_axi.S_AXI_WDATA;
    wr_strb             = w_got ? wstrb_q : s_axi.S_AXI_WSTRB;
    unique case (w_state)
      W_IDLE: begin
        s_axi.S_AXI_AWREADY = !aw_got;
        s_axi.S_AXI_WREADY  = !w_got;
        aw_hs  = s_axi.S_AXI_AWVALID && !aw_got;
        w_hs   = s_axi.S_AXI_WVALID && !w_got;
        commit = (aw_got || aw_hs) && (w_got || w_hs);
        if (commit) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi.S_AXI_BVALID = 1'b1;
        if (s_axi.S_AXI_BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state           <= W_IDLE;
      aw_got            <= 1'b0;
      w_got             <= 1'b0;
      awidx_q           <= '0;
      wdata_q           <= '0;
      wstrb_q           <= '0;
      s_axi.S_AXI_BRESP <= RESP_OKAY;
      reg0              <= '0;
      reg1              <= '0;
      reg3              <= '0;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) begin
        aw_got  <= 1'b1;
        awidx_q <= s_axi.S_AXI_AWADDR[4:2];
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
      if (commit) begin
        aw_got            <= 1'b0;
        w_got             <= 1'b0;
        s_axi.S_AXI_BRESP <= wr_idx[2] ? RESP_SLVERR : RESP_OKAY;
        case (wr_idx)
          3'd0:    reg0 <= merge_bytes(reg0, wr_data, wr_strb);
          3'd1:    reg1 <= merge_bytes(reg1, wr_data, wr_strb);
          3'd3:    reg3 <= merge_bytes(reg3, wr_data, wr_strb);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pmod_ext                   = '0;
    pmod_ext[PMOD_WIDTH-1:0]   = sync2;
  end

  always_comb begin
    unique case (s_axi.S_AXI_ARADDR[4:2])
      3'd0:    rd_word = reg0;
      3'd1:    rd_word = reg1;
      3'd2:    rd_word = pmod_ext;
      3'd3:    rd_word = reg3;
      default: rd_word = '0;
    endcase
  end

  always_comb begin
    r_state_nxt         = r_state;
    s_axi.S_AXI_ARREADY = 1'b0;
    s_axi.S_AXI_RVALID  = 1'b0;
    ar_hs               = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s_axi.S_AXI_ARREADY = 1'b1;
        if (s_axi.S_AXI_ARVALID) begin
          ar_hs       = 1'b1;
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        s_axi.S_AXI_RVALID = 1'b1;
        if (s_axi.S_AXI_RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read data is taken from the register values before any same-edge write commit.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state           <= R_IDLE;
      s_axi.S_AXI_RDATA <= '0;
      s_axi.S_AXI_RRESP <= RESP_OKAY;
      sync1             <= '0;
      sync2             <= '0;
    end else begin
      r_state <= r_state_nxt;
      sync1   <= pmod_in;
      sync2   <= sync1;
      if (ar_hs) begin
        s_axi.S_AXI_RDATA <= rd_word;
        s_axi.S_AXI_RRESP <= s_axi.S_AXI_ARADDR[4] ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end
endmodule

// File: tb/tb_pmod_axil_slave_regs.sv
// Self-checking bench for pmod_axil_slave_regs: directed AXI-Lite scenarios plus
// randomized traffic compared against a word-array register model.
module tb_pmod_axil_slave_regs;
  localparam int PW = 8;

  logic          tb_ACLK = 1'b0;
  logic          ARESET;
  logic [PW-1:0] pmod_out, pmod_oe, pmod_in;
  int            errors = 0;
  int            checks = 0;
  logic [31:0]   mreg [4];

  always #5 tb_ACLK = ~tb_ACLK;

  pmod_axil_slave_regs_if #(.ADDR_WIDTH(5)) bus ();

  pmod_axil_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PMOD_WIDTH(PW)) dut (
    .ACLK     (tb_ACLK),
    .ARESET   (ARESET),
    .s_axi    (bus.slave),
    .pmod_out (pmod_out),
    .pmod_oe  (pmod_oe),
    .pmod_in  (pmod_in)
  );

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 32'h0;
  endfunction

  function automatic logic [1:0] model_write(input logic [4:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int w;
    w = int'(addr) / 4;
    if (w >= 4) return 2'b10;
    if (w == 2) return 2'b00;
    for (int b = 0; b < 4; b++)
      if (strb[b]) mreg[w][8*b +: 8] = data[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [4:0] addr);
    int w;
    w = int'(addr) / 4;
    if (w >= 4) return {2'b10, 32'h0};
    if (w == 2) return {2'b00, 32'(pmod_in)};
    return {2'b00, mreg[w]};
  endfunction

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  // order: 0 = AW and W together, 1 = AW one cycle ahead, 2 = W one cycle ahead
  task automatic wr_issue(input logic [4:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int order);
    bit aw_done = 0, w_done = 0, aw_go, w_go, aw_hs, w_hs;
    int cyc = 0;
    aw_go = (order != 2);
    w_go  = (order != 1);
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_WDATA  = data;
    bus.S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 20) begin
      bus.S_AXI_AWVALID = aw_go && !aw_done;
      bus.S_AXI_WVALID  = w_go && !w_done;
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      tick();
      cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      if (order == 1 && aw_done) w_go = 1;
      if (order == 2 && w_done)  aw_go = 1;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    checks++;
    if (!(aw_done && w_done)) begin
      errors++;
      $display("FAIL wr_issue_timeout: aw_done=%0d w_done=%0d required 1 1", aw_done, w_done);
    end
  endtask

  task automatic wr_resp(output logic [1:0] resp);
    int cyc = 0;
    while (!bus.S_AXI_BVALID && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (!bus.S_AXI_BVALID) begin
      errors++;
      $display("FAIL bvalid_timeout: BVALID=%b required 1", bus.S_AXI_BVALID);
    end
    resp = bus.S_AXI_BRESP;
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic rd_issue(input logic [4:0] addr);
    bit hs = 0;
    int cyc = 0;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    while (!hs && cyc < 20) begin
      hs = bus.S_AXI_ARREADY;
      tick();
      cyc++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL ar_timeout: ARREADY never seen, required 1");
    end
  endtask

  task automatic rd_resp(output logic [31:0] data, output logic [1:0] resp);
    int cyc = 0;
    while (!bus.S_AXI_RVALID && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (!bus.S_AXI_RVALID) begin
      errors++;
      $display("FAIL rvalid_timeout: RVALID=%b required 1", bus.S_AXI_RVALID);
    end
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int order, output logic [1:0] resp);
    wr_issue(addr, data, strb, order);
    wr_resp(resp);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    rd_issue(addr);
    rd_resp(data, resp);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    logic [4:0]  addrs [3];
    ARESET = 1'b1;
    repeat (3) tick();
    ARESET = 1'b0;
    model_reset();
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
         bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_handshake: aw/w/ar ready,b/r valid=%b required 11100",
               {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                bus.S_AXI_BVALID, bus.S_AXI_RVALID});
    end
    checks++;
    if (pmod_out !== 8'h00 || pmod_oe !== 8'h00) begin
      errors++;
      $display("FAIL reset_pins: out=%h oe=%h required 00 00", pmod_out, pmod_oe);
    end
    addrs[0] = 5'h00; addrs[1] = 5'h04; addrs[2] = 5'h0C;
    foreach (addrs[i]) begin
      axi_read(addrs[i], d, r);
      checks++;
      if (d !== 32'h0 || r !== 2'b00) begin
        errors++;
        $display("FAIL reset_read_%h: data=%h resp=%b required 00000000 00", addrs[i], d, r);
      end
    end
  endtask

  task automatic test_write_order();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h00, 32'h0101FFFF, 4'hF, 1, r);
    void'(model_write(5'h00, 32'h0101FFFF, 4'hF));
    checks++;
    if (r !== 2'b00 || pmod_out !== 8'hFF) begin
      errors++;
      $display("FAIL aw_first_write: bresp=%b pmod_out=%h required 00 ff", r, pmod_out);
    end
    axi_read(5'h00, d, r);
    checks++;
    if (d !== 32'h0101FFFF || r !== 2'b00) begin
      errors++;
      $display("FAIL aw_first_readback: data=%h resp=%b required 0101ffff 00", d, r);
    end
    axi_write(5'h0C, 32'hABCD0001, 4'hF, 2, r);
    void'(model_write(5'h0C, 32'hABCD0001, 4'hF));
    axi_read(5'h0C, d, r);
    checks++;
    if (d !== 32'hABCD0001 || r !== 2'b00) begin
      errors++;
      $display("FAIL w_first_readback: data=%h resp=%b required abcd0001 00", d, r);
    end
    axi_write(5'h04, 32'h0000003C, 4'hF, 0, r);
    void'(model_write(5'h04, 32'h0000003C, 4'hF));
    checks++;
    if (pmod_oe !== 8'h3C) begin
      errors++;
      $display("FAIL oe_write: pmod_oe=%h required 3c", pmod_oe);
    end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h0C, 32'hDEAD0011, 4'hF, 0, r);
    axi_write(5'h0C, 32'hBEEF0000, 4'b1100, 0, r);
    axi_read(5'h0C, d, r);
    checks++;
    if (d !== 32'hBEEF0011) begin
      errors++;
      $display("FAIL partial_strobe: data=%h required beef0011", d);
    end
    axi_write(5'h0C, 32'h12345678, 4'b0000, 1, r);
    axi_read(5'h0C, d, r);
    checks++;
    if (d !== 32'hBEEF0011 || r !== 2'b00) begin
      errors++;
      $display("FAIL zero_strobe: data=%h resp=%b required beef0011 00", d, r);
    end
    mreg[3] = 32'hBEEF0011;
  endtask

  task automatic test_ro_unmapped();
    logic [31:0] d;
    logic [1:0]  r;
    pmod_in = 8'h5A;
    repeat (4) tick();
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h0000005A || r !== 2'b00) begin
      errors++;
      $display("FAIL ro_read: data=%h resp=%b required 0000005a 00", d, r);
    end
    axi_write(5'h08, 32'hFFFFFFFF, 4'hF, 0, r);
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h0000005A || r !== 2'b00) begin
      errors++;
      $display("FAIL ro_write_ignored: data=%h resp=%b required 0000005a 00", d, r);
    end
    axi_write(5'h14, 32'hCAFEF00D, 4'hF, 0, r);
    checks++;
    if (r !== 2'b10) begin
      errors++;
      $display("FAIL unmapped_bresp: bresp=%b required 10", r);
    end
    axi_read(5'h14, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++;
      $display("FAIL unmapped_read: data=%h resp=%b required 00000000 10", d, r);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, held;
    logic [1:0]  r;
    wr_issue(5'h04, 32'h000000A5, 4'hF, 0);
    void'(model_write(5'h04, 32'h000000A5, 4'hF));
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b100) begin
        errors++;
        $display("FAIL b_stall_%0d: bvalid/awready/wready=%b required 100", i,
                 {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
      end
      tick();
    end
    wr_resp(r);
    checks++;
    if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_WREADY !== 1'b1 || pmod_oe !== 8'hA5) begin
      errors++;
      $display("FAIL b_release: awready=%b wready=%b oe=%h required 1 1 a5",
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, pmod_oe);
    end
    rd_issue(5'h0C);
    held = mreg[3];
    axi_write(5'h0C, 32'h0F0F0F0F, 4'hF, 0, r);
    void'(model_write(5'h0C, 32'h0F0F0F0F, 4'hF));
    repeat (2) tick();
    checks++;
    if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== held) begin
      errors++;
      $display("FAIL r_stall: rvalid=%b rdata=%h required 1 %h",
               bus.S_AXI_RVALID, bus.S_AXI_RDATA, held);
    end
    rd_resp(d, r);
  endtask

  task automatic test_same_edge();
    logic [31:0] d, old;
    logic [1:0]  r;
    old = mreg[0];
    bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_WDATA = 32'h77665544; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 5'h00;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    void'(model_write(5'h00, 32'h77665544, 4'hF));
    checks++;
    if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_RVALID !== 1'b1 || pmod_out !== 8'h44) begin
      errors++;
      $display("FAIL same_edge_valid: bvalid=%b rvalid=%b out=%h required 1 1 44",
               bus.S_AXI_BVALID, bus.S_AXI_RVALID, pmod_out);
    end
    wr_resp(r);
    rd_resp(d, r);
    checks++;
    if (d !== old) begin
      errors++;
      $display("FAIL same_edge_prewrite: data=%h required %h", d, old);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    logic [1:0]  r;
    rd_issue(5'h00);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    model_reset();
    checks++;
    if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b1 || bus.S_AXI_RDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_read: rvalid=%b arready=%b rdata=%h required 0 1 00000000",
               bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RDATA);
    end
    axi_read(5'h00, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_cleared_reg0: data=%h required 00000000", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, data;
    logic [1:0]  r, er;
    logic [33:0] exp_rd;
    logic [4:0]  addr;
    logic [3:0]  strb;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        pmod_in = PW'($urandom);
        repeat (3) tick();
      end
      addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom);
        axi_write(addr, data, strb, int'($urandom_range(0, 2)), r);
        er = model_write(addr, data, strb);
        checks++;
        if (r !== er || pmod_out !== mreg[0][PW-1:0] || pmod_oe !== mreg[1][PW-1:0]) begin
          errors++;
          $display("FAIL rand_write_%0d: addr=%h bresp=%b out=%h oe=%h required %b %h %h",
                   n, addr, r, pmod_out, pmod_oe, er, mreg[0][PW-1:0], mreg[1][PW-1:0]);
        end
      end else begin
        axi_read(addr, d, r);
        exp_rd = model_read(addr);
        checks++;
        if ({r, d} !== exp_rd) begin
          errors++;
          $display("FAIL rand_read_%0d: addr=%h resp/data=%h required %h", n, addr, {r, d}, exp_rd);
        end
      end
    end
  endtask

  initial begin
    ARESET = 1'b1;
    pmod_in = '0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    model_reset();
    test_reset();
    test_write_order();
    test_partial_strobe();
    test_ro_unmapped();
    test_backpressure();
    test_same_edge();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
